dma_cfg_regs: RTL and testbench
===============================

Name: dma_cfg_regs

Overview:
ICB slave register bank that the E203 CPU programs to drive the DMA engine. It holds the source, destination, length and control/status registers, and issues a one-cycle start pulse. It tracks busy/done from the engine's completion signal and raises the interrupt request toward the PLIC. It sits directly upstream of dma_core, feeding src_addr_reg, dst_addr_reg, len_addr_reg, sta_addr_reg and start.

Parameters:
BASE_ADDR, 32'h1000_0000, base of the 4 KB register window; decode compares addr[31:12].
ID_VALUE, 32'hD3A0_0001, read-only identification word at offset 0x10.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous assertion, active-low
icb_cmd_valid  in  1  CPU command valid
icb_cmd_ready  out  1  command accepted
icb_cmd_addr  in  32  byte address
icb_cmd_read  in  1  1 = read, 0 = write
icb_cmd_wdata  in  32  write data
icb_cmd_wmask  in  4  byte write enables
icb_rsp_valid  out  1  response valid
icb_rsp_ready  in  1  CPU accepts response
icb_rsp_rdata  out  32  read data
icb_rsp_err  out  1  error response
dma_done  in  1  completion level from engine (its dma_irq)
src_addr_reg  out  32  source start address
dst_addr_reg  out  32  destination start address
len_addr_reg  out  32  transfer count; bits [1:0] also encode element size
sta_addr_reg  out  8  status image {4'b0, done, busy, ie, 1'b0}
start  out  1  one-cycle launch pulse to engine
irq  out  1  interrupt request = done & ie

Behaviour:
- Reset: all registers, outputs, rsp_valid, rsp_err, start, busy, done and ie go to 0. icb_cmd_ready resets to 1.
- Register map (offset = addr[4:2]):
  - 0x00 SRC (RW).
  - 0x04 DST (RW).
  - 0x08 LEN (RW).
  - 0x0C CTRL: bit0 START (write 1, reads 0); bit1 IE (RW); bit2 BUSY (RO); bit3 DONE (write 1 to clear).
  - 0x10 ID (RO).
- Decode errors: these return rsp_err=1 and rdata=0, with no state change.
  - addr[31:12] != BASE_ADDR[31:12].
  - addr[1:0] != 0.
  - offset above 0x10 or addr[11:5] nonzero.
  - write to ID.
- Handshake:
  - Only one transaction is outstanding at a time. icb_cmd_ready = ~rsp_valid | icb_rsp_ready.
  - A command is accepted on valid & ready. rsp_valid asserts on the next cycle, with rdata and err registered.
  - rsp_valid, rdata and err hold stable until rsp_ready. Back-to-back transactions sustain one per cycle when rsp_ready is held high.
- Writes:
  - Each byte lane is written only when its wmask bit is set.
  - CTRL uses byte 0 only. wmask[0]=0 means no CTRL effect, with an OK response.
- Busy lockout: while busy=1, writes to SRC/DST/LEN and START=1 are discarded and the response has err=1. IE and DONE-clear are still honoured.
- Start acceptance:
  - START=1 with busy=0 and LEN!=0 generates start=1 for exactly the cycle after acceptance and sets busy in that same cycle.
  - START=1 with LEN==0 returns err=1; no pulse, busy stays 0.
- Completion:
  - dma_done is registered; a rising edge (prev 0, now 1) clears busy and sets done.
  - Levels or rising edges while busy=0 are ignored.
- Simultaneous events:
  - A done-set edge in the same cycle as a DONE W1C leaves done=1 (set wins).
  - A completion edge in the same cycle a START write is accepted: busy is sampled before the update, so START is rejected with err=1.
- irq is combinational from registered done & ie. Clearing ie masks it without clearing done.
- Reads return current values. CTRL read = {28'b0, done, busy, ie, 1'b0}. sta_addr_reg mirrors CTRL[7:0].
- Reset mid-transfer clears busy, done and any pending response immediately. A pending start pulse is dropped.

Test Plan:
- Reset, then read all offsets -> SRC/DST/LEN/CTRL = 0, ID = 32'hD3A0_0001, err=0; outputs all 0.
- Write SRC=0x8000_0100 with wmask=4'b0011 over reset value -> readback 0x0000_0100; src_addr_reg matches.
- LEN=16, then CTRL=0x3 -> start high for exactly 1 cycle, CTRL reads 0x6. A second START while busy -> err=1, no pulse. A SRC write while busy -> err=1, value unchanged.
- Raise dma_done while busy with ie=1 -> CTRL reads 0xA, irq=1. Write CTRL=0x8 -> irq=0. Issue W1C in the same cycle as a new done edge -> done stays 1.
- Access addr BASE+0x14, BASE+0x02, 0x2000_0000, and write ID -> err=1 each, rdata=0, no register change. LEN=0 with START -> err=1, no pulse.
- Hold rsp_ready=0 for 3 cycles after a read -> cmd_ready=0, rsp stable. Then run 4 back-to-back writes with rsp_ready=1 -> 4 responses in 4 consecutive cycles.

Source files
------------

// File: rtl/dma_cfg_regs.sv
// ICB register bank for the DMA engine: SRC/DST/LEN/CTRL/ID, start pulse, busy/done tracking, irq.
// One-cycle registered response; cmd_ready drops only while a response is stalled by rsp_ready.
module dma_cfg_regs #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter logic [31:0] ID_VALUE  = 32'hD3A0_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        icb_cmd_valid,
  output logic        icb_cmd_ready,
  input  logic [31:0] icb_cmd_addr,
  input  logic        icb_cmd_read,
  input  logic [31:0] icb_cmd_wdata,
  input  logic [3:0]  icb_cmd_wmask,
  output logic        icb_rsp_valid,
  input  logic        icb_rsp_ready,
  output logic [31:0] icb_rsp_rdata,
  output logic        icb_rsp_err,
  input  logic        dma_done,
  output logic [31:0] src_addr_reg,
  output logic [31:0] dst_addr_reg,
  output logic [31:0] len_addr_reg,
  output logic [7:0]  sta_addr_reg,
  output logic        start,
  output logic        irq
);

  localparam logic [2:0] OFF_SRC  = 3'd0;
  localparam logic [2:0] OFF_DST  = 3'd1;
  localparam logic [2:0] OFF_LEN  = 3'd2;
  localparam logic [2:0] OFF_CTRL = 3'd3;
  localparam logic [2:0] OFF_ID   = 3'd4;

  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] len_q, len_d;
  logic        ie_q, ie_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        start_q, start_d;
  logic        dma_done_q, dma_done_prev_q;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        cmd_hs;
  logic        dec_err;
  logic        done_edge;
  logic        acc_err;
  logic        start_go;
  logic        done_clr;
  logic [2:0]  off;
  logic [31:0] rd_val;
  logic [31:0] ctrl_img;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  // Single outstanding transaction: a new command may enter as the old response leaves.
  assign icb_cmd_ready = ~rsp_valid_q | icb_rsp_ready;
  assign cmd_hs        = icb_cmd_valid & icb_cmd_ready;

  assign off     = icb_cmd_addr[4:2];
  assign dec_err = (icb_cmd_addr[31:12] != BASE_ADDR[31:12])
                 | (icb_cmd_addr[1:0] != 2'b00)
                 | (icb_cmd_addr[11:5] != 7'd0)
                 | (off > OFF_ID)
                 | (~icb_cmd_read & (off == OFF_ID));

  assign ctrl_img  = {28'd0, done_q, busy_q, ie_q, 1'b0};
  // Completion only counts as an edge on the registered level, and only while a transfer runs.
  assign done_edge = dma_done_q & ~dma_done_prev_q & busy_q;

  always_comb begin
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    ie_d        = ie_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    acc_err     = 1'b0;
    rd_val      = 32'd0;
    start_go    = 1'b0;
    done_clr    = 1'b0;

    if (cmd_hs) begin
      if (dec_err) begin
        acc_err = 1'b1;
      end else if (icb_cmd_read) begin
        unique case (off)
          OFF_SRC:  rd_val = src_q;
          OFF_DST:  rd_val = dst_q;
          OFF_LEN:  rd_val = len_q;
          OFF_CTRL: rd_val = ctrl_img;
          default:  rd_val = ID_VALUE;
        endcase
      end else begin
        unique case (off)
          OFF_SRC: begin
            if (busy_q) acc_err = 1'b1;
            else        src_d   = merge_lanes(src_q, icb_cmd_wdata, icb_cmd_wmask);
          end
          OFF_DST: begin
            if (busy_q) acc_err = 1'b1;
            else        dst_d   = merge_lanes(dst_q, icb_cmd_wdata, icb_cmd_wmask);
          end
          OFF_LEN: begin
            if (busy_q) acc_err = 1'b1;
            else        len_d   = merge_lanes(len_q, icb_cmd_wdata, icb_cmd_wmask);
          end
          OFF_CTRL: begin
            if (icb_cmd_wmask[0]) begin
              ie_d     = icb_cmd_wdata[1];
              done_clr = icb_cmd_wdata[3];
              if (icb_cmd_wdata[0]) begin
                if (busy_q || (len_q == 32'd0)) acc_err  = 1'b1;
                else                            start_go = 1'b1;
              end
            end
          end
          default: acc_err = 1'b1;
        endcase
      end
      rsp_valid_d = 1'b1;
      rsp_rdata_d = acc_err ? 32'd0 : rd_val;
      rsp_err_d   = acc_err;
    end else if (icb_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // A completion edge beats a same-cycle DONE clear; start and completion are mutually exclusive.
  always_comb begin
    done_d  = done_q;
    busy_d  = busy_q;
    start_d = start_go;
    if (done_edge)     done_d = 1'b1;
    else if (done_clr) done_d = 1'b0;
    if (done_edge)     busy_d = 1'b0;
    else if (start_go) busy_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q           <= 32'd0;
      dst_q           <= 32'd0;
      len_q           <= 32'd0;
      ie_q            <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      start_q         <= 1'b0;
      dma_done_q      <= 1'b0;
      dma_done_prev_q <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= 32'd0;
      rsp_err_q       <= 1'b0;
    end else begin
      src_q           <= src_d;
      dst_q           <= dst_d;
      len_q           <= len_d;
      ie_q            <= ie_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      start_q         <= start_d;
      dma_done_q      <= dma_done;
      dma_done_prev_q <= dma_done_q;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_err_q       <= rsp_err_d;
    end
  end

  assign icb_rsp_valid = rsp_valid_q;
  assign icb_rsp_rdata = rsp_rdata_q;
  assign icb_rsp_err   = rsp_err_q;
  assign src_addr_reg  = src_q;
  assign dst_addr_reg  = dst_q;
  assign len_addr_reg  = len_q;
  assign sta_addr_reg  = ctrl_img[7:0];
  assign start         = start_q;
  assign irq           = done_q & ie_q;

endmodule

// File: tb/tb_dma_cfg_regs.sv
// Randomised scoreboard bench for dma_cfg_regs against a register-level reference model.
module tb_dma_cfg_regs;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] IDV  = 32'hD3A0_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [31:0] icb_cmd_addr, icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
  logic [31:0] icb_rsp_rdata;
  logic        dma_done;
  logic [31:0] src_addr_reg, dst_addr_reg, len_addr_reg;
  logic [7:0]  sta_addr_reg;
  logic        start, irq;

  always #5 clk = ~clk;

  dma_cfg_regs dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
    .dma_done(dma_done),
    .src_addr_reg(src_addr_reg), .dst_addr_reg(dst_addr_reg),
    .len_addr_reg(len_addr_reg), .sta_addr_reg(sta_addr_reg),
    .start(start), .irq(irq)
  );

  typedef struct packed { logic [31:0] rdata; logic err; } rsp_t;
  rsp_t exp_q[$];
  int   pop_cyc[$];
  int   errors = 0, checks = 0;
  int   act_starts = 0, exp_starts = 0, cyc = 0;

  logic [31:0] m_src, m_dst, m_len;
  logic        m_ie, m_busy, m_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_src = 0; m_dst = 0; m_len = 0; m_ie = 0; m_busy = 0; m_done = 0;
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] wd,
                                        input logic [3:0] wm);
    logic [31:0] v;
    v = old_v;
    for (int b = 0; b < 4; b++) if (wm[b]) v[8*b +: 8] = wd[8*b +: 8];
    return v;
  endfunction

  // Reference behaviour of one accepted command, evaluated against pre-command state.
  task automatic model_cmd(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] wm, output logic [31:0] rdata, output logic err);
    logic [31:0] off;
    bit ok;
    off   = addr - BASE;
    ok    = ((addr >> 12) == (BASE >> 12)) && (addr % 4 == 0) && (off <= 16);
    rdata = 0;
    err   = 0;
    if (!ok) err = 1;
    else if (rd) begin
      case (off)
        0:       rdata = m_src;
        4:       rdata = m_dst;
        8:       rdata = m_len;
        12:      rdata = 8 * m_done + 4 * m_busy + 2 * m_ie;
        default: rdata = IDV;
      endcase
    end else begin
      case (off)
        0:  if (m_busy) err = 1; else m_src = lanes(m_src, wd, wm);
        4:  if (m_busy) err = 1; else m_dst = lanes(m_dst, wd, wm);
        8:  if (m_busy) err = 1; else m_len = lanes(m_len, wd, wm);
        12: if (wm[0]) begin
              m_ie = wd[1];
              if (wd[3]) m_done = 0;
              if (wd[0]) begin
                if (m_busy || m_len == 0) err = 1;
                else begin m_busy = 1; exp_starts++; end
              end
            end
        default: err = 1;
      endcase
    end
  endtask

  // Entered and left at posedge+1; inputs stay stable across the accepting edge.
  task automatic issue(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] wm);
    rsp_t e;
    logic [31:0] r;
    logic er;
    int n;
    icb_cmd_valid = 1; icb_cmd_read = rd; icb_cmd_addr = addr;
    icb_cmd_wdata = wd; icb_cmd_wmask = wm;
    n = 0;
    @(negedge clk);
    while (!icb_cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_accept", 32'(icb_cmd_ready), 32'd1);
    model_cmd(rd, addr, wd, wm, r, er);
    e.rdata = r; e.err = er;
    exp_q.push_back(e);
    @(posedge clk); #1;
    icb_cmd_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin @(posedge clk); n++; end while (exp_q.size() != 0 && n < 100);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_src"}, src_addr_reg, m_src);
    check({tag, "_dst"}, dst_addr_reg, m_dst);
    check({tag, "_len"}, len_addr_reg, m_len);
    check({tag, "_sta"}, 32'(sta_addr_reg), 8 * m_done + 4 * m_busy + 2 * m_ie);
    check({tag, "_irq"}, 32'(irq), 32'(m_done & m_ie));
    check({tag, "_starts"}, act_starts, exp_starts);
  endtask

  task automatic complete();
    dma_done = 1;
    repeat (2) @(posedge clk);
    #1;
    if (m_busy) begin m_busy = 0; m_done = 1; end
    dma_done = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Command lands on the same edge that the completion edge takes effect.
  task automatic edge_with_cmd(input logic [31:0] wd);
    dma_done = 1;
    @(posedge clk); #1;
    issue(0, BASE + 12, wd, 4'h1);
    if (m_busy) begin m_busy = 0; m_done = 1; end
    dma_done = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    rsp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (start === 1'b1) act_starts++;
      if (rst_n && icb_rsp_valid && icb_rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got rdata %h with no expected entry", icb_rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", icb_rsp_rdata, e.rdata);
          check("rsp_err", 32'(icb_rsp_err), 32'(e.err));
          pop_cyc.push_back(cyc);
        end
      end
    end
  endtask

  initial begin
    logic [31:0] a, w;
    logic [3:0]  m;
    int          sel;
    rst_n = 0; icb_cmd_valid = 0; icb_cmd_read = 0; icb_cmd_addr = 0;
    icb_cmd_wdata = 0; icb_cmd_wmask = 0; icb_rsp_ready = 1; dma_done = 0;
    model_reset();
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(icb_cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(icb_rsp_valid), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check_outputs("rst");
    rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i <= 4; i++) issue(1, BASE + 4 * i, 0, 0);
    drain();

    issue(0, BASE, 32'h8000_0100, 4'b0011);
    issue(1, BASE, 0, 0);
    drain();
    check_outputs("src_partial");

    issue(0, BASE + 8, 16, 4'hF);
    issue(0, BASE + 12, 32'h3, 4'h1);
    check("start_pulse_hi", 32'(start), 32'd1);
    @(posedge clk); #1;
    check("start_pulse_lo", 32'(start), 32'd0);
    issue(1, BASE + 12, 0, 0);
    issue(0, BASE + 12, 32'h3, 4'h1);
    issue(0, BASE, 32'h1234_5678, 4'hF);
    issue(1, BASE, 0, 0);
    drain();
    check_outputs("busy_lock");

    complete();
    issue(1, BASE + 12, 0, 0);
    drain();
    check("irq_set", 32'(irq), 32'd1);
    issue(0, BASE + 12, 32'h8, 4'h1);
    drain();
    check_outputs("w1c");
    issue(0, BASE + 12, 32'h2, 4'h1);
    issue(0, BASE + 12, 32'h3, 4'h1);
    edge_with_cmd(32'hA);
    drain();
    check_outputs("w1c_vs_edge");
    issue(0, BASE + 12, 32'h3, 4'h1);
    edge_with_cmd(32'h3);
    drain();
    check_outputs("start_vs_edge");

    issue(1, BASE + 32'h14, 0, 0);
    issue(1, BASE + 32'h02, 0, 0);
    issue(1, 32'h2000_0000, 0, 0);
    issue(0, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
    issue(0, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF);
    issue(0, BASE + 8, 0, 4'hF);
    issue(0, BASE + 12, 32'h1, 4'h1);
    issue(0, BASE + 12, 32'h1, 4'h0);
    issue(1, BASE + 8, 0, 0);
    drain();
    check_outputs("dec_err");

    icb_rsp_ready = 0;
    issue(1, BASE, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", 32'(icb_rsp_valid), 32'd1);
      check("hold_cmd_ready", 32'(icb_cmd_ready), 32'd0);
      check("hold_rdata", icb_rsp_rdata, m_src);
    end
    @(posedge clk); #1;
    icb_rsp_ready = 1;
    drain();
    pop_cyc.delete();
    for (int i = 0; i < 4; i++) issue(0, BASE + 4 * (i % 3), 32'hA5A5_0000 + i, 4'hF);
    drain();
    check("b2b_count", 32'(pop_cyc.size()), 32'd4);
    for (int i = 0; i + 1 < pop_cyc.size(); i++)
      check("b2b_gap", pop_cyc[i+1] - pop_cyc[i], 32'd1);

    for (int i = 0; i < 300; i++) begin
      if (m_busy && $urandom_range(0, 7) == 0) complete();
      else begin
        sel = $urandom_range(0, 8);
        if (sel <= 4)      a = BASE + 4 * sel;
        else if (sel == 5) a = BASE + 4 * $urandom_range(5, 1023);
        else if (sel == 6) a = BASE + ($urandom & 32'hFFF);
        else if (sel == 7) a = BASE + 12;
        else               a = $urandom;
        w = $urandom;
        if (a == BASE + 12) w = w & 32'hF;
        if (a == BASE + 8 && $urandom_range(0, 3) == 0) w = 0;
        m = 4'($urandom);
        issue(1'($urandom_range(0, 1)), a, w, m);
      end
    end
    drain();
    check_outputs("random");

    if (m_busy) complete();
    issue(0, BASE + 8, 4, 4'hF);
    issue(0, BASE + 12, 32'h3, 4'h1);
    rst_n = 0;
    #1;
    check("rst_mid_start", 32'(start), 32'd0);
    check("rst_mid_sta", 32'(sta_addr_reg), 32'd0);
    check("rst_mid_rsp_valid", 32'(icb_rsp_valid), 32'd0);
    exp_q.delete();
    exp_starts--;  // the pulse was killed by reset before the monitor could see it
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk); #1;
    issue(1, BASE + 12, 0, 0);
    issue(1, BASE + 8, 0, 0);
    drain();
    check_outputs("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
